// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack port plus the decode-side
// valid/ready port with the retiring instruction's redirect information.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic        redirect_type;
  logic [31:0] imm32;
  logic [31:0] rs1_data;
  logic        fetch_err;
  logic [1:0]  err_code;
  logic [31:0] instret;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output inst, pc, pc_plus4, inst_valid,
    input  inst_ready, redirect, redirect_type, imm32, rs1_data,
    output fetch_err, err_code, instret
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  inst, pc, pc_plus4, inst_valid,
    output inst_ready, redirect, redirect_type, imm32, rs1_data,
    input  fetch_err, err_code, instret
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches over req/ack, presents instructions to
// decode and picks the next PC from the retiring instruction's outcome.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  state_t      state;
  logic [CW-1:0] wait_cnt;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] instret_q;
  logic [1:0]  err_q;
  logic        req_q;
  logic        valid_q;
  logic        ferr_q;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] next_pc;

  // JALR drops bit 0 before the alignment check; B/JAL targets are used as-is.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    target   = bus.redirect_type ? ((bus.rs1_data + bus.imm32) & ~32'h1)
                                 : (pc_q + bus.imm32);
    next_pc  = bus.redirect ? target : pc_plus4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      instret_q <= 32'd0;
      wait_cnt  <= '0;
      err_q     <= 2'b00;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (bus.imem_ack) begin
            inst_q   <= bus.imem_rdata;
            wait_cnt <= '0;
            state    <= VALID;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
          end else if (wait_cnt == LAST_WAIT) begin
            wait_cnt <= '0;
            state    <= ERR;
            req_q    <= 1'b0;
            ferr_q   <= 1'b1;
            err_q    <= 2'b01;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        VALID: begin
          if (bus.inst_ready) begin
            instret_q <= instret_q + 32'd1;
            valid_q   <= 1'b0;
            // A misaligned target still retires the instruction but keeps its PC.
            if (next_pc[1]) begin
              state  <= ERR;
              ferr_q <= 1'b1;
              err_q  <= 2'b10;
            end else begin
              pc_q  <= next_pc;
              state <= REQ;
              req_q <= 1'b1;
            end
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.inst_valid = valid_q;
  assign bus.fetch_err  = ferr_q;
  assign bus.err_code   = err_q;
  assign bus.instret    = instret_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: acts as instruction memory and
// decode, tracking expected PC/instret/error state in a transaction-level model.
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 4;

  logic clk;
  logic rst;
  int   assertions;
  int   failures;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_instret;
  logic        m_err;
  logic [1:0]  m_code;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = $urandom;
    bus.inst_ready    = 1'b0;
    bus.redirect      = 1'($urandom);
    bus.redirect_type = 1'($urandom);
    bus.imm32         = $urandom;
    bus.rs1_data      = $urandom;
  endtask

  // Asynchronous reset, optionally with a stray ack during the IDLE cycle.
  task automatic do_reset(input bit late_ack);
    rst = 1'b0;
    bus.imem_ack = late_ack;
    #1;
    check_output("rst_req", bus.imem_req, 1'b0);
    check_output("rst_valid", bus.inst_valid, 1'b0);
    check_output("rst_ferr", bus.fetch_err, 1'b0);
    check_output("rst_code", bus.err_code, 2'b00);
    check_output("rst_pc", bus.pc, RESET_PC);
    check_output("rst_inst", bus.inst, 32'd0);
    check_output("rst_instret", bus.instret, 32'd0);
    m_pc = RESET_PC; m_inst = 32'd0; m_instret = 32'd0; m_err = 1'b0; m_code = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("idle_req", bus.imem_req, 1'b0);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check_output("req_after_rst", bus.imem_req, 1'b1);
    check_output("addr_after_rst", bus.imem_addr, RESET_PC);
    check_output("late_ack_inst", bus.inst, 32'd0);
    check_output("late_ack_valid", bus.inst_valid, 1'b0);
  endtask

  // Entered at a negedge with imem_req expected high.
  task automatic fetch_one(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) begin
      check_output("wait_req", bus.imem_req, 1'b1);
      check_output("wait_addr", bus.imem_addr, m_pc);
      check_output("wait_valid", bus.inst_valid, 1'b0);
      @(negedge clk);
    end
    check_output("ack_req", bus.imem_req, 1'b1);
    check_output("ack_addr", bus.imem_addr, m_pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    m_inst = word;
    check_output("valid", bus.inst_valid, 1'b1);
    check_output("inst", bus.inst, m_inst);
    check_output("pc", bus.pc, m_pc);
    check_output("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    check_output("valid_req", bus.imem_req, 1'b0);
    check_output("valid_instret", bus.instret, m_instret);
    check_output("valid_ferr", bus.fetch_err, 1'b0);
  endtask

  task automatic retire(input int stall, input logic rd, input logic rt,
                        input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] nxt;
    for (int i = 0; i < stall; i++) begin
      drive_idle_inputs();
      @(negedge clk);
      check_output("stall_valid", bus.inst_valid, 1'b1);
      check_output("stall_inst", bus.inst, m_inst);
      check_output("stall_pc", bus.pc, m_pc);
      check_output("stall_req", bus.imem_req, 1'b0);
      check_output("stall_instret", bus.instret, m_instret);
    end
    bus.inst_ready    = 1'b1;
    bus.redirect      = rd;
    bus.redirect_type = rt;
    bus.imm32         = imm;
    bus.rs1_data      = rs1;
    @(negedge clk);
    drive_idle_inputs();
    if (!rd)      nxt = m_pc + 32'd4;
    else if (!rt) nxt = m_pc + imm;
    else          nxt = (rs1 + imm) & 32'hFFFF_FFFE;
    m_instret = m_instret + 32'd1;
    check_output("ret_instret", bus.instret, m_instret);
    check_output("ret_valid", bus.inst_valid, 1'b0);
    if (nxt[1]) begin
      m_err = 1'b1; m_code = 2'b10;
      check_output("mis_ferr", bus.fetch_err, 1'b1);
      check_output("mis_code", bus.err_code, 2'b10);
      check_output("mis_pc", bus.pc, m_pc);
      check_output("mis_req", bus.imem_req, 1'b0);
    end else begin
      m_pc = nxt;
      check_output("next_req", bus.imem_req, 1'b1);
      check_output("next_addr", bus.imem_addr, m_pc);
      check_output("next_ferr", bus.fetch_err, 1'b0);
    end
  endtask

  task automatic run_timeout();
    for (int i = 0; i < MAX_WAIT; i++) begin
      check_output("to_req", bus.imem_req, 1'b1);
      check_output("to_ferr", bus.fetch_err, 1'b0);
      @(negedge clk);
    end
    m_err = 1'b1; m_code = 2'b01;
    check_output("to_err", bus.fetch_err, 1'b1);
    check_output("to_code", bus.err_code, 2'b01);
    check_output("to_req_low", bus.imem_req, 1'b0);
    check_output("to_pc", bus.pc, m_pc);
  endtask

  // Error state must ignore ready/redirect/ack and hold everything.
  task automatic err_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.inst_ready = 1'b1;
      bus.redirect   = 1'b1;
      bus.imem_ack   = 1'b1;
      @(negedge clk);
      check_output("err_req", bus.imem_req, 1'b0);
      check_output("err_valid", bus.inst_valid, 1'b0);
      check_output("err_ferr", bus.fetch_err, 1'b1);
      check_output("err_code", bus.err_code, m_code);
      check_output("err_pc", bus.pc, m_pc);
      check_output("err_instret", bus.instret, m_instret);
    end
    drive_idle_inputs();
  endtask

  task automatic apply_stimulus();
    logic [31:0] imm;
    logic [31:0] rs1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        run_timeout();
        err_hold(2);
        do_reset(1'($urandom));
      end else if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        do_reset(1'b1);
      end else begin
        fetch_one($urandom_range(0, MAX_WAIT - 1), $urandom);
        imm = 32'(($urandom_range(0, 63) - 32) * 4);
        if ($urandom_range(0, 7) == 0) imm = imm + 32'd2;
        rs1 = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) rs1 = rs1 | 32'd2;
        retire($urandom_range(0, 3), 1'($urandom), 1'($urandom), imm, rs1);
        if (m_err) begin
          err_hold(2);
          do_reset(1'($urandom));
        end
      end
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    rst = 1'b0;
    drive_idle_inputs();
    @(negedge clk);
    do_reset(1'b0);

    fetch_one(0, 32'h00500093);
    retire(0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      fetch_one(0, $urandom);
      retire(0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    check_output("seq_instret", bus.instret, 32'd4);
    check_output("seq_addr", bus.imem_addr, 32'h10);

    fetch_one(1, $urandom);
    retire(5, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0);
    check_output("br_addr", bus.imem_addr, 32'h08);
    fetch_one(0, $urandom);
    retire(0, 1'b1, 1'b1, 32'h20, 32'h101);
    check_output("jalr_addr", bus.imem_addr, 32'h120);
    fetch_one(2, $urandom);
    retire(0, 1'b1, 1'b0, 32'hFFFF_FF20, 32'd0);
    check_output("jump_addr", bus.imem_addr, 32'h40);
    fetch_one(0, $urandom);
    retire(0, 1'b1, 1'b0, 32'h6, 32'd0);
    check_output("mis_pc40", bus.pc, 32'h40);
    err_hold(4);
    do_reset(1'b0);

    run_timeout();
    err_hold(2);
    do_reset(1'b0);
    fetch_one(MAX_WAIT - 1, 32'hDEAD_BEEF);
    retire(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    do_reset(1'b1);

    apply_stimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
